// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one fixed-latency memory between the CPU datapath and a DMA engine.
// CPU has priority; DMA wins after STARVE_LIMIT consecutive CPU grants made while it was waiting.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_ack,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        owner
);

  localparam int unsigned LW = $clog2(MEM_LATENCY + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [LW-1:0] LAT_MAX    = LW'(MEM_LATENCY);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic [31:0]   cpu_rdata_q, cpu_rdata_d;
  logic [31:0]   dma_rdata_q, dma_rdata_d;

  logic grant_dma;
  logic grant_cpu;

  assign grant_dma = dma_req && (!cpu_req || (starve_cnt_q == STARVE_MAX));
  assign grant_cpu = cpu_req && !grant_dma;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_dma || grant_cpu) begin
          owner_d   = grant_dma;
          we_d      = grant_dma ? dma_we    : cpu_we;
          addr_d    = grant_dma ? dma_addr  : cpu_addr;
          wdata_d   = grant_dma ? dma_wdata : cpu_wdata;
          lat_cnt_d = LW'(1);
          state_d   = ACCESS;
          // Only CPU grants that bypass a waiting DMA count towards starvation.
          if (grant_cpu && dma_req) begin
            if (starve_cnt_q != STARVE_MAX) starve_cnt_d = starve_cnt_q + 1'b1;
          end else begin
            starve_cnt_d = '0;
          end
        end
      end
      ACCESS: begin
        if (lat_cnt_q == LAT_MAX) begin
          if (!we_q) begin
            if (owner_q) dma_rdata_d = mem_rdata;
            else         cpu_rdata_d = mem_rdata;
          end
          state_d = DONE;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  // Strobes decode straight from state so an asynchronous reset drops them at once.
  always_comb begin
    mem_read  = (state_q == ACCESS) && !we_q;
    mem_write = (state_q == ACCESS) && we_q;
    cpu_ack   = (state_q == DONE) && !owner_q;
    dma_ack   = (state_q == DONE) && owner_q;
    busy      = (state_q != IDLE);
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LATENCY=2, STARVE_LIMIT=4 and a read-only memory.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] dma_addr = '0, dma_wdata = '0;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ack, dma_ack, mem_read, mem_write, busy, owner;

  logic [31:0] mem [0:127];
  int errors = 0;
  int checks = 0;

  assign mem_rdata = mem[mem_addr[8:2]];

  mem_port_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Uncontended access: request, LAT access cycles, ack cycle, then release.
  task automatic access(input logic is_dma, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata);
    if (is_dma) begin
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    for (int k = 0; k < LAT; k++) begin
      tick();
      chk("acc_mem_read", 32'(mem_read), 32'(!we));
      chk("acc_mem_write", 32'(mem_write), 32'(we));
      chk("acc_mem_addr", mem_addr, addr);
      if (we) chk("acc_mem_wdata", mem_wdata, wdata);
      chk("acc_owner", 32'(owner), 32'(is_dma));
      chk("acc_no_ack", 32'({cpu_ack, dma_ack}), 32'(0));
    end
    tick();
    chk("done_cpu_ack", 32'(cpu_ack), 32'(!is_dma));
    chk("done_dma_ack", 32'(dma_ack), 32'(is_dma));
    chk("done_strobes", 32'({mem_read, mem_write}), 32'(0));
    tick();
    chk("after_ack", 32'({cpu_ack, dma_ack, busy}), 32'(0));
    if (is_dma) dma_req = 1'b0;
    else        cpu_req = 1'b0;
  endtask

  initial begin
    logic [5:0]  seq;
    int          n;
    int          t [0:2];
    int          k;
    int          cyc;
    logic        pending;
    logic        drop_dma;
    logic        dma_seen;

    for (int i = 0; i < 128; i++) mem[i] = 32'hA500_0000 | i;
    mem[0]  = 32'h1111_0000;
    mem[1]  = 32'h2222_0004;
    mem[2]  = 32'h3333_0008;
    mem[3]  = 32'h4444_000C;
    mem[16] = 32'hDEAD_BEEF;
    mem[64] = 32'hCAFE_F00D;

    // Reset state
    tick(); tick();
    chk("rst_outputs", 32'({cpu_ack, dma_ack, mem_read, mem_write, busy, owner}), 32'(0));
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_starve", 32'(dut.starve_cnt_q), 32'(0));
    reset = 1'b1;
    tick();

    // CPU read of 0x40
    access(1'b0, 1'b0, 32'h40, 32'h0);
    chk("cpu_rd_data", cpu_rdata, 32'hDEAD_BEEF);
    chk("cpu_rd_dma_untouched", dma_rdata, 32'h0);

    // DMA write leaves both read registers alone
    access(1'b1, 1'b1, 32'h100, 32'h1234_5678);
    chk("dma_wr_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("dma_wr_dma_rdata", dma_rdata, 32'h0);

    // DMA read of 0x100
    access(1'b1, 1'b0, 32'h100, 32'h0);
    chk("dma_rd_data", dma_rdata, 32'hCAFE_F00D);
    chk("dma_rd_cpu_untouched", cpu_rdata, 32'hDEAD_BEEF);

    // Simultaneous requests with starve count 0: CPU first, then DMA
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h4;
    tick();
    chk("sim_owner_cpu", 32'(owner), 32'(0));
    chk("sim_addr_cpu", mem_addr, 32'h0);
    tick(); tick();
    chk("sim_cpu_ack", 32'({cpu_ack, dma_ack}), 32'(2));
    chk("sim_cpu_data", cpu_rdata, 32'h1111_0000);
    tick();
    cpu_req = 1'b0;
    tick();
    chk("sim_owner_dma", 32'(owner), 32'(1));
    chk("sim_addr_dma", mem_addr, 32'h4);
    tick(); tick();
    chk("sim_dma_ack", 32'({cpu_ack, dma_ack}), 32'(1));
    chk("sim_dma_data", dma_rdata, 32'h2222_0004);
    tick();
    dma_req = 1'b0;

    // Starvation: CPU hammers while DMA waits
    cpu_req = 1'b1; cpu_addr = 32'h8;
    dma_req = 1'b1; dma_addr = 32'hC;
    seq = '0; n = 0; drop_dma = 1'b0; dma_seen = 1'b0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      tick();
      if (drop_dma) begin
        dma_req = 1'b0;
        drop_dma = 1'b0;
      end
      if (cpu_ack && dma_ack) chk("starve_both_ack", 32'(1), 32'(0));
      if (busy && owner && !dma_seen) begin
        dma_seen = 1'b1;
        chk("starve_cnt_after_dma_grant", 32'(dut.starve_cnt_q), 32'(0));
      end
      if (cpu_ack) begin
        n++;
        if (n == 4) chk("starve_cnt_sat", 32'(dut.starve_cnt_q), 32'(4));
      end else if (dma_ack) begin
        seq[n] = 1'b1;
        n++;
        drop_dma = 1'b1;
      end
    end
    chk("starve_ack_count", 32'(n), 32'(6));
    chk("starve_order", 32'(seq), 32'(6'b01_0000));
    chk("starve_dma_data", dma_rdata, 32'h4444_000C);
    chk("starve_cpu_data", cpu_rdata, 32'h3333_0008);
    tick();
    cpu_req = 1'b0;
    tick();

    // Asynchronous reset in the first access cycle aborts cleanly
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    tick();
    chk("abort_pre_read", 32'(mem_read), 32'(1));
    #1 reset = 1'b0;
    #1;
    chk("abort_read_drop", 32'(mem_read), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_rdata_clr", cpu_rdata, 32'h0);
    tick();
    chk("abort_no_ack", 32'({cpu_ack, dma_ack}), 32'(0));
    tick();
    reset = 1'b1;
    access(1'b0, 1'b0, 32'h40, 32'h0);
    chk("abort_restart_data", cpu_rdata, 32'hDEAD_BEEF);

    // Back-to-back CPU reads at 0x0, 0x4, 0x8
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;
    k = 0; cyc = 0; pending = 1'b0;
    t[0] = 0; t[1] = 0; t[2] = 0;
    while (cyc < 40 && k < 3) begin
      tick();
      cyc++;
      if (pending) begin
        cpu_addr = 32'(k * 4);
        pending = 1'b0;
      end
      if (cpu_ack) begin
        chk("b2b_data", cpu_rdata, mem[k]);
        t[k] = cyc;
        k++;
        pending = 1'b1;
      end
    end
    chk("b2b_count", 32'(k), 32'(3));
    chk("b2b_gap1", 32'(t[1] - t[0]), 32'(LAT + 2));
    chk("b2b_gap2", 32'(t[2] - t[1]), 32'(LAT + 2));
    tick();
    cpu_req = 1'b0;
    tick();
    chk("final_idle", 32'(busy), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified Memory block between two requesters: the multicycle CPU datapath (port cpu) and a program-loader/DMA engine (port dma).
- Sits between both requesters and the Memory instance.
- Drives Mem_Read, Mem_Write, Address and Write_data for a configurable fixed-latency access.
- Returns read data and a one-cycle acknowledge to the winning requester.

Parameters:
MEM_LATENCY, 1, cycles mem_read/mem_write stay asserted per access; must be at least 1; mem_rdata is valid on the last of these cycles.
STARVE_LIMIT, 4, consecutive CPU grants made while dma_req is high, after which dma wins the next arbitration; must be at least 1.

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset
cpu_req  input  1  CPU access request, level, held until cpu_ack
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  32  CPU byte address
cpu_wdata  input  32  CPU write data
cpu_rdata  output  32  registered CPU read data
cpu_ack  output  1  one-cycle completion pulse
dma_req  input  1  DMA access request, level, held until dma_ack
dma_we  input  1  1 = write, 0 = read
dma_addr  input  32  DMA byte address
dma_wdata  input  32  DMA write data
dma_rdata  output  32  registered DMA read data
dma_ack  output  1  one-cycle completion pulse
mem_read  output  1  to Memory Mem_Read
mem_write  output  1  to Memory Mem_Write
mem_addr  output  32  to Memory Address
mem_wdata  output  32  to Memory Write_data
mem_rdata  input  32  from Memory Mem_Data
busy  output  1  high in ACCESS and DONE
owner  output  1  0 = cpu, 1 = dma; last or current grant

Behaviour:
- Reset low, asynchronous:
  - state=IDLE, all outputs 0, starvation counter 0, latency counter 0, owner=0.
  - Takes effect immediately, including mid-access: mem_read/mem_write drop without waiting for an edge, and no ack is issued for the aborted access.
- Requester rules:
  - req, we, addr and wdata must be held stable from assertion through the ack cycle.
  - In the cycle after ack, the requester drops req or presents a new request.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Arbitrates on the rising edge.
  - Grants dma if dma_req and (not cpu_req or starve_cnt==STARVE_LIMIT). Otherwise grants cpu if cpu_req. Otherwise stays in IDLE.
  - On grant: owner, we, addr and wdata are latched into internal registers; latency counter loads 1; go to ACCESS.
- ACCESS:
  - mem_addr and mem_wdata are driven from the latched registers.
  - mem_read=~we and mem_write=we, asserted for exactly MEM_LATENCY consecutive cycles.
  - On the last cycle, a read captures mem_rdata into the owner's rdata register.
  - Then go to DONE.
- DONE:
  - The owner's ack is high for one cycle; mem_read=mem_write=0.
  - Next state is IDLE.
- Outside ACCESS: mem_addr and mem_wdata hold their last value; mem_read=mem_write=0.
- Latency: request sampled in IDLE at edge N → ACCESS cycles N+1..N+MEM_LATENCY → ack during cycle N+MEM_LATENCY+1. Minimum request-to-request spacing is MEM_LATENCY+2 cycles.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, on each cpu grant made while dma_req=1.
  - Clears to 0 on a dma grant, or on any cpu grant while dma_req=0.
- rdata registers:
  - Change only on completion of a read for that port.
  - Writes and the other port's accesses leave them unchanged.
- Only one ack per access. cpu_ack and dma_ack are never high together.
- A request that deasserts before grant is ignored, which is a protocol violation but harmless.
- No address decoding or alignment checks; addresses pass through unchanged.

Test Plan:
- CPU read, MEM_LATENCY=2: memory returns 0xDEADBEEF at 0x40; cpu_req at edge 0 → mem_read high in cycles 1–2, mem_addr=0x40, cpu_ack in cycle 3, cpu_rdata=0xDEADBEEF, dma_rdata unchanged.
- DMA write 0x12345678 to 0x100 → mem_write high for exactly MEM_LATENCY cycles with mem_addr=0x100 and mem_wdata=0x12345678; dma_ack a single pulse; cpu_rdata and dma_rdata unchanged.
- cpu_req and dma_req rise on the same edge, starve_cnt=0 → cpu served first; dma served next; owner goes 0 then 1.
- CPU re-requests continuously while dma_req is held, STARVE_LIMIT=4 → exactly 4 CPU accesses, then the DMA access, then CPU resumes; the counter reads 0 after the dma grant.
- Reset pulled low during cycle 1 of a 3-cycle ACCESS → mem_read falls immediately, no ack, state IDLE. After release, the held request restarts from arbitration and completes normally.
- Back-to-back CPU reads at addresses 0x0, 0x4, 0x8, MEM_LATENCY=1 → acks spaced exactly 3 cycles apart, with correct data for each.
